icache_direct: RTL and testbench

- Read-only, direct-mapped instruction cache between the fetch stage's port A (read_a/address_a/rdata_a/resp_a) and the line-granular physical-memory interface.
- Supplies 16-bit instruction words to fetch: same-cycle response on a hit, single-line fill on a miss.
- Read-only: port A never writes, so the block needs no dirty state or write-back path.
- Exposes hit and miss counters for performance bring-up.

---
 rtl/icache_direct_if.sv | 28 ++
 rtl/icache_direct.sv | 148 ++++++++++++++
 tb/tb_icache_direct.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_direct_if
// Description : Fetch port A and line-fill memory bundle for icache_direct.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_direct_if;
    logic         read_a;
    logic [15:0]  address_a;
    logic         resp_a;
    logic [15:0]  rdata_a;
    logic         pmem_read;
    logic [15:0]  pmem_address;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    // Environment side: fetch requester plus physical memory responder
    modport master (
        output read_a, address_a, pmem_resp, pmem_rdata,
        input  resp_a, rdata_a, pmem_read, pmem_address
    );

    modport slave (
        input  read_a, address_a, pmem_resp, pmem_rdata,
        output resp_a, rdata_a, pmem_read, pmem_address
    );
endinterface
`default_nettype wire

// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
// Module      : icache_direct
// Description : Read-only direct-mapped instruction cache, zero-cycle hit,
//               single-line fill on miss, saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_direct #(
    parameter int NUM_SETS   = 8,
    parameter int LINE_WORDS = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    icache_direct_if.slave            bus,
    output logic [CNT_WIDTH-1:0]      hit_count,
    output logic [CNT_WIDTH-1:0]      miss_count
);

    localparam int c_idx_w  = $clog2(NUM_SETS);
    localparam int c_tag_w  = 12 - c_idx_w;
    localparam int c_line_w = LINE_WORDS * 16;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_fill    = 2'd1;
    localparam logic [1:0] c_st_respond = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;

    logic [NUM_SETS-1:0]   r_valid;
    logic [c_tag_w-1:0]    r_tag  [NUM_SETS];
    logic [c_line_w-1:0]   r_data [NUM_SETS];

    logic [11:0]           r_miss_line;
    logic [CNT_WIDTH-1:0]  r_hit_count;
    logic [CNT_WIDTH-1:0]  r_miss_count;

    logic [2:0]            w_offset;
    logic [c_idx_w-1:0]    w_index;
    logic [c_tag_w-1:0]    w_tag;
    logic [c_idx_w-1:0]    w_miss_index;
    logic [c_tag_w-1:0]    w_miss_tag;
    logic                  w_hit;
    logic                  w_resp;
    logic                  w_miss_start;
    logic                  w_install;
    logic                  w_pmem_read;
    logic                  w_unused;

    assign w_offset     = bus.address_a[3:1];
    assign w_index      = bus.address_a[3+c_idx_w:4];
    assign w_tag        = bus.address_a[15:4+c_idx_w];
    assign w_miss_index = r_miss_line[c_idx_w-1:0];
    assign w_miss_tag   = r_miss_line[11:c_idx_w];
    assign w_unused     = bus.address_a[0];

    assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_resp       = 1'b0;
        w_miss_start = 1'b0;
        w_install    = 1'b0;
        w_pmem_read  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.read_a) begin
                    if (w_hit) begin
                        w_resp = 1'b1;
                    end else begin
                        w_miss_start = 1'b1;
                        w_state_next = c_st_fill;
                    end
                end
            end
            c_st_fill: begin
                w_pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    w_install    = 1'b1;
                    w_state_next = c_st_respond;
                end
            end
            c_st_respond: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_install) begin
            r_valid[w_miss_index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone gate their use
    always_ff @(posedge clk) begin
        if (w_install) begin
            r_tag[w_miss_index]  <= w_miss_tag;
            r_data[w_miss_index] <= bus.pmem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_miss_start) begin
            r_miss_line <= bus.address_a[15:4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_resp && (r_hit_count != c_cnt_max)) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_miss_start && (r_miss_count != c_cnt_max)) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    assign bus.resp_a       = w_resp;
    assign bus.rdata_a      = r_data[w_index][{w_offset, 4'b0000} +: 16];
    assign bus.pmem_read    = w_pmem_read;
    assign bus.pmem_address = {r_miss_line, 4'b0000};
    assign hit_count        = r_hit_count;
    assign miss_count       = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_direct
// Description : Directed self-checking bench for icache_direct (CNT_WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_direct;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] hit_count;
    logic [3:0] miss_count;

    int n_cmp    = 0;
    int n_err    = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    logic [127:0] line0;

    always #5 clk = ~clk;

    icache_direct_if bus ();

    icache_direct #(
        .NUM_SETS   (8),
        .LINE_WORDS (8),
        .CNT_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic logic [127:0] gen_line(input logic [15:0] seed);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = seed + 16'(w);
        return l;
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_hits"}, hit_count, exp_hit[3:0]);
        chk({tag, "_misses"}, miss_count, exp_miss[3:0]);
    endtask

    // Miss from IDLE, fill after lat FILL cycles, RESPOND, then the refill hit
    task automatic do_miss(input logic [15:0] addr, input logic [127:0] line, input int lat);
        cyc();
        bus.read_a    = 1'b1;
        bus.address_a = addr;
        settle();
        chk("miss_lookup_resp", bus.resp_a, 0);
        for (int i = 0; i < lat; i++) begin
            cyc();
            if (i == 0) exp_miss = sat(exp_miss + 1);
            if (i == lat - 1) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = line;
            end
            settle();
            chk("fill_pmem_read", bus.pmem_read, 1);
            chk("fill_pmem_address", bus.pmem_address, {addr[15:4], 4'h0});
            chk("fill_resp", bus.resp_a, 0);
        end
        chk_counts("fill");
        cyc();
        bus.pmem_resp = 1'b0;
        settle();
        chk("respond_resp", bus.resp_a, 0);
        chk("respond_pmem_read", bus.pmem_read, 0);
        cyc();
        settle();
        chk("refill_hit_resp", bus.resp_a, 1);
        chk("refill_hit_data", bus.rdata_a, line[addr[3:1]*16 +: 16]);
        exp_hit = sat(exp_hit + 1);
    endtask

    initial begin
        line0          = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
        bus.read_a     = 1'b0;
        bus.address_a  = 16'h0000;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        reset          = 1'b1;

        cyc();
        cyc();
        settle();
        chk("reset_resp", bus.resp_a, 0);
        chk("reset_pmem_read", bus.pmem_read, 0);
        chk_counts("reset");
        reset = 1'b0;

        // First miss and the hit on the same line
        do_miss(16'h0012, line0, 3);
        cyc();
        bus.address_a = 16'h001E;
        settle();
        chk("hit_1e_resp", bus.resp_a, 1);
        chk("hit_1e_data", bus.rdata_a, 16'h7777);
        chk("hit_1e_pmem_read", bus.pmem_read, 0);
        chk_counts("after_first_hit");
        exp_hit = sat(exp_hit + 1);
        cyc();
        bus.read_a = 1'b0;
        settle();
        chk("idle_resp", bus.resp_a, 0);
        chk_counts("after_hit_1e");

        // Conflict misses on set 1
        do_miss(16'h0090, gen_line(16'hA000), 2);
        do_miss(16'h0010, line0, 1);
        cyc();
        bus.read_a = 1'b0;
        settle();
        chk_counts("conflict");

        // Redirect during FILL
        do_miss(16'h0020, gen_line(16'hB000), 2);
        cyc();
        bus.address_a = 16'h0100;
        settle();
        chk("redir_lookup_resp", bus.resp_a, 0);
        cyc();
        exp_miss = sat(exp_miss + 1);
        bus.address_a = 16'h0020;
        settle();
        chk("redir_pmem_read", bus.pmem_read, 1);
        chk("redir_pmem_address", bus.pmem_address, 16'h0100);
        chk("redir_fill_resp", bus.resp_a, 0);
        cyc();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = gen_line(16'hC000);
        settle();
        chk("redir_pmem_address_2", bus.pmem_address, 16'h0100);
        cyc();
        bus.pmem_resp = 1'b0;
        settle();
        chk("redir_respond_resp", bus.resp_a, 0);
        chk("redir_respond_pmem_read", bus.pmem_read, 0);
        cyc();
        settle();
        chk("redir_hit_20_resp", bus.resp_a, 1);
        chk("redir_hit_20_data", bus.rdata_a, 16'hB000);
        exp_hit = sat(exp_hit + 1);
        cyc();
        bus.address_a = 16'h0106;
        settle();
        chk("redir_hit_106_resp", bus.resp_a, 1);
        chk("redir_hit_106_data", bus.rdata_a, 16'hC003);
        exp_hit = sat(exp_hit + 1);
        cyc();
        bus.read_a = 1'b0;
        settle();
        chk_counts("redirect");

        // read_a withdrawn during FILL
        cyc();
        bus.read_a    = 1'b1;
        bus.address_a = 16'h0030;
        settle();
        chk("drop_lookup_resp", bus.resp_a, 0);
        cyc();
        exp_miss = sat(exp_miss + 1);
        bus.read_a     = 1'b0;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = gen_line(16'hD000);
        settle();
        chk("drop_pmem_read", bus.pmem_read, 1);
        cyc();
        bus.pmem_resp = 1'b0;
        settle();
        chk("drop_respond_resp", bus.resp_a, 0);
        chk("drop_respond_pmem_read", bus.pmem_read, 0);
        cyc();
        settle();
        chk("drop_idle_resp", bus.resp_a, 0);
        cyc();
        bus.read_a    = 1'b1;
        bus.address_a = 16'h0034;
        settle();
        chk("drop_hit_resp", bus.resp_a, 1);
        chk("drop_hit_data", bus.rdata_a, 16'hD002);
        exp_hit = sat(exp_hit + 1);

        // Stray pmem_resp in IDLE must not touch set 3
        cyc();
        bus.read_a     = 1'b0;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = gen_line(16'h5A00);
        settle();
        chk("stray_pmem_read", bus.pmem_read, 0);
        chk_counts("stray");
        cyc();
        bus.pmem_resp = 1'b0;
        settle();
        chk("stray_after_pmem_read", bus.pmem_read, 0);
        cyc();
        bus.read_a    = 1'b1;
        bus.address_a = 16'h0030;
        settle();
        chk("stray_hit_resp", bus.resp_a, 1);
        chk("stray_hit_data", bus.rdata_a, 16'hD000);
        exp_hit = sat(exp_hit + 1);

        // Reset during FILL
        cyc();
        bus.address_a = 16'h0040;
        settle();
        chk("rst_lookup_resp", bus.resp_a, 0);
        cyc();
        exp_miss = sat(exp_miss + 1);
        settle();
        chk("rst_fill_pmem_read", bus.pmem_read, 1);
        chk_counts("pre_reset");
        reset = 1'b1;
        cyc();
        reset          = 1'b0;
        bus.read_a     = 1'b0;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = gen_line(16'hE000);
        exp_hit        = 0;
        exp_miss       = 0;
        settle();
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_resp", bus.resp_a, 0);
        chk_counts("reset_mid_fill");
        cyc();
        bus.pmem_resp = 1'b0;
        settle();
        chk("late_resp_pmem_read", bus.pmem_read, 0);
        do_miss(16'h0010, line0, 2);

        // Saturating hit counter
        for (int i = 0; i < 17; i++) begin
            cyc();
            settle();
            chk("sat_resp", bus.resp_a, 1);
            chk("sat_hit_count", hit_count, exp_hit[3:0]);
            exp_hit = sat(exp_hit + 1);
        end
        cyc();
        bus.read_a = 1'b0;
        settle();
        chk("sat_final", hit_count, 4'hF);
        chk("sat_miss_count", miss_count, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
